// File: rtl/bit_order_pipe.sv
// bit_order_pipe: per-beat bit/lane reordering stage feeding a DEPTH-entry valid/ready FIFO.
// Optional transfer counter enabled by defining BIT_ORDER_PIPE_STATS_EN.
module bit_order_pipe #(
   parameter int LANE_W = 4,
   parameter int LANES  = 3,
   parameter int DEPTH  = 2,
   localparam int W  = LANES * LANE_W,
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [1:0]    in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [LW-1:0] level,
   input  logic          stats_clr,
   output logic [15:0]   xfer_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [W-1:0] rev_bits, rev_lanes, rev_word, xformed;
   logic push, pop;
   always_comb begin
      rev_bits  = '0;
      rev_lanes = '0;
      rev_word  = '0;
      for (int k = 0; k < LANES; k++) begin
         for (int b = 0; b < LANE_W; b++) rev_bits[k*LANE_W+b] = in_data[k*LANE_W+LANE_W-1-b];
         rev_lanes[k*LANE_W +: LANE_W] = in_data[(LANES-1-k)*LANE_W +: LANE_W];
      end
      for (int i = 0; i < W; i++) rev_word[i] = in_data[W-1-i];
      xformed = in_mode == 2'd0 ? in_data :
                in_mode == 2'd1 ? rev_bits :
                in_mode == 2'd2 ? rev_lanes : rev_word;
   end
   assign in_ready  = level != FULL;
   assign out_valid = level != '0;
   assign out_data  = mem[rd_ptr];
   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= xformed;
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push != pop) level <= push ? level + LW'(1) : level - LW'(1);
      end
   end
`ifdef BIT_ORDER_PIPE_STATS_EN
   logic [15:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (stats_clr) cnt <= '0;
      else if (pop && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
   end
   assign xfer_cnt = cnt;
`else
   logic unused_clr;
   assign unused_clr = stats_clr;
   assign xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_bit_order_pipe.sv
// tb_bit_order_pipe: scoreboard bench for bit_order_pipe at default parameters.
module tb_bit_order_pipe;
   logic        clk = 0, rst_n = 0;
   logic        in_valid = 0, out_ready = 0, stats_clr = 0;
   logic        in_ready, out_valid;
   logic [11:0] in_data = '0, out_data;
   logic [1:0]  in_mode = '0;
   logic [1:0]  level;
   logic [15:0] xfer_cnt;
   logic [11:0] q[$];
   int checks = 0, errors = 0;

   bit_order_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .level(level), .stats_clr(stats_clr), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   // bit-reverse lanes first, then swap lanes; mode 3 is the composition of both
   function automatic logic [11:0] model(input logic [11:0] d, input logic [1:0] m);
      logic [11:0] r, s;
      r = d;
      if (m[0]) for (int k = 0; k < 3; k++) for (int b = 0; b < 4; b++) r[k*4+b] = d[k*4+3-b];
      s = r;
      if (m[1]) for (int k = 0; k < 3; k++) s[k*4 +: 4] = r[(2-k)*4 +: 4];
      return s;
   endfunction

   always @(negedge clk) begin
      logic [11:0] e;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected out_data=%h with empty scoreboard", out_data);
            end else begin
               e = q.pop_front();
               if (out_data !== e) begin
                  errors++;
                  $display("FAIL sb_data got %h expected %h", out_data, e);
               end
            end
         end
         if (in_valid && in_ready) q.push_back(model(in_data, in_mode));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (level !== 2'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold level=%0d out_valid=%b expected 0/0", level, out_valid);
      end
      rst_n = 1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== 2'd0 || out_data !== 12'h000) begin
         errors++;
         $display("FAIL reset_idle in_ready=%b out_valid=%b level=%0d out_data=%h expected 1/0/0/000",
                  in_ready, out_valid, level, out_data);
      end
      checks++;
      if (xfer_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d expected 0", xfer_cnt);
      end
   endtask

   task automatic test_modes;
      logic [11:0] exp [4];
      exp[0] = 12'h1A3; exp[1] = 12'h85C; exp[2] = 12'h3A1; exp[3] = 12'hC58;
      out_ready = 1;
      in_valid  = 1;
      in_data   = 12'h1A3;
      for (int m = 0; m < 4; m++) begin
         in_mode = 2'(m);
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp[m]) begin
            errors++;
            $display("FAIL mode%0d out_valid=%b out_data=%h expected 1/%h", m, out_valid, out_data, exp[m]);
         end
      end
      in_valid = 0;
      tick();
      checks++;
      if (level !== 2'd0) begin
         errors++;
         $display("FAIL modes_drain level=%0d expected 0", level);
      end
   endtask

   task automatic test_full;
      out_ready = 0;
      in_mode   = 2'd0;
      in_valid  = 1;
      in_data   = 12'h111;
      tick();
      in_data = 12'h222;
      tick();
      checks++;
      if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 12'h111) begin
         errors++;
         $display("FAIL full level=%0d in_ready=%b out_data=%h expected 2/0/111", level, in_ready, out_data);
      end
      in_data = 12'h333;
      tick();
      checks++;
      if (level !== 2'd2 || out_data !== 12'h111) begin
         errors++;
         $display("FAIL full_hold level=%0d out_data=%h expected 2/111", level, out_data);
      end
      out_ready = 1;
      tick();
      checks++;
      if (level !== 2'd1 || in_ready !== 1'b1 || out_data !== 12'h222) begin
         errors++;
         $display("FAIL full_pop level=%0d in_ready=%b out_data=%h expected 1/1/222", level, in_ready, out_data);
      end
      tick();
      checks++;
      if (level !== 2'd1 || out_data !== 12'h333) begin
         errors++;
         $display("FAIL full_accept level=%0d out_data=%h expected 1/333", level, out_data);
      end
      in_valid = 0;
      tick();
      checks++;
      if (level !== 2'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_drain level=%0d out_valid=%b expected 0/0", level, out_valid);
      end
   endtask

   task automatic test_back_to_back;
      out_ready = 0;
      in_valid  = 1;
      in_data   = 12'($urandom);
      in_mode   = 2'($urandom);
      tick();
      out_ready = 1;
      for (int i = 0; i < 7; i++) begin
         in_data = 12'($urandom);
         in_mode = 2'($urandom);
         tick();
         checks++;
         if (level !== 2'd1) begin
            errors++;
            $display("FAIL b2b_level beat%0d got %0d expected 1", i, level);
         end
      end
      in_valid = 0;
      tick();
      checks++;
      if (level !== 2'd0) begin
         errors++;
         $display("FAIL b2b_drain level=%0d expected 0", level);
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 0;
      in_mode   = 2'd0;
      in_valid  = 1;
      in_data   = 12'hABC;
      tick();
      in_data = 12'hDEF;
      tick();
      in_valid = 0;
      #2 rst_n = 0;
      q.delete();
      #1;
      checks++;
      if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== 12'h000) begin
         errors++;
         $display("FAIL rst_mid level=%0d out_valid=%b out_data=%h expected 0/0/000", level, out_valid, out_data);
      end
      #2 rst_n = 1;
      out_ready = 1;
      tick(2);
      checks++;
      if (out_valid !== 1'b0 || level !== 2'd0) begin
         errors++;
         $display("FAIL rst_mid_stale out_valid=%b level=%0d expected 0/0", out_valid, level);
      end
      in_valid = 1;
      in_data  = 12'h5A5;
      in_mode  = 2'd3;
      tick();
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 12'hA5A) begin
         errors++;
         $display("FAIL rst_mid_push out_valid=%b out_data=%h expected 1/a5a", out_valid, out_data);
      end
      tick();
   endtask

   task automatic test_stats;
      logic [15:0] e5, esat, emid;
`ifdef BIT_ORDER_PIPE_STATS_EN
      e5 = 16'd5; emid = 16'hFFFE; esat = 16'hFFFF;
`else
      e5 = 16'd0; emid = 16'd0; esat = 16'd0;
`endif
      stats_clr = 1;
      tick();
      stats_clr = 0;
      checks++;
      if (xfer_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stats_clr got %0d expected 0", xfer_cnt);
      end
      out_ready = 1;
      in_valid  = 1;
      for (int i = 0; i < 5; i++) begin
         in_data = 12'($urandom);
         in_mode = 2'($urandom);
         tick();
      end
      in_valid = 0;
      tick();
      checks++;
      if (xfer_cnt !== e5) begin
         errors++;
         $display("FAIL stats_five got %0d expected %0d", xfer_cnt, e5);
      end
      in_valid = 1;
      tick();
      in_valid  = 0;
      stats_clr = 1;
      tick();
      stats_clr = 0;
      checks++;
      if (xfer_cnt !== 16'd0 || level !== 2'd0) begin
         errors++;
         $display("FAIL stats_clr_pop cnt=%0d level=%0d expected 0/0", xfer_cnt, level);
      end
`ifdef BIT_ORDER_PIPE_STATS_EN
      in_valid = 1;
      in_data  = 12'($urandom);
      tick(65535);
      checks++;
      if (xfer_cnt !== emid) begin
         errors++;
         $display("FAIL stats_near_sat got %h expected %h", xfer_cnt, emid);
      end
      tick();
      checks++;
      if (xfer_cnt !== esat) begin
         errors++;
         $display("FAIL stats_sat got %h expected %h", xfer_cnt, esat);
      end
      tick(3);
      in_valid = 0;
      tick();
      checks++;
      if (xfer_cnt !== esat) begin
         errors++;
         $display("FAIL stats_sat_hold got %h expected %h", xfer_cnt, esat);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_modes();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_stats();
      tick(2);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover %0d entries never emitted, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
